// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared RV32 fetch constants and the buffered fetch entry type
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry instruction buffer with push, pop, flush and head outputs
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  entries [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Flush wins over both push and pop so a redirect leaves nothing stale behind.
  assign do_push = push & !flush;
  assign do_pop  = pop & !flush & (count != '0);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_entry;
  end

  assign head = (count != '0) ? entries[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC walker issuing word reads and buffering fetched instructions for decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RESETn,
  output logic [31:0] memory_address,
  output logic        memory_read_strobe,
  input  logic [31:0] memory_read_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misaligned
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int UW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_inflight;
  logic          inflight;
  logic          misaligned;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;
  logic [UW-1:0] used;
  logic [UW-1:0] limit;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign pop = instr_valid & instr_ready;

  // Credit check: buffered + in-flight must stay within DEPTH after this cycle's pop.
  assign used  = {1'b0, count} + UW'(inflight);
  assign limit = UW'(DEPTH) + UW'(pop);

  assign memory_read_strobe = RESETn & !redirect_valid & (used < limit);
  assign memory_address     = fetch_pc;

  assign push       = inflight & !redirect_valid;
  assign push_entry = '{pc: pc_inflight, instr: memory_read_data};

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      fetch_pc    <= RESET_PC;
      pc_inflight <= '0;
      inflight    <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      inflight <= memory_read_strobe;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) misaligned <= 1'b1;
      end else if (memory_read_strobe) begin
        pc_inflight <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'(INSTR_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESETn),
    .flush     (redirect_valid),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign instr_valid      = (count != '0);
  assign instr_pc         = head.pc;
  assign instr_data       = head.instr;
  assign fetch_misaligned = misaligned;

endmodule
